param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO for the conv write-back path; successor to the fixed 61-deep FIFO.
//  Supports any depth (including non-power-of-2), programmable almost-full/almost-empty thresholds,
//  a fill count, first-word-fall-through (FWFT) or registered read, sticky overflow/underflow flags,
//  synchronous flush, and lossless simultaneous read+write at full. Sits between the PE array and the output writer.
// PARAMETERS
//  DATA_WIDTH  25  word width in bits
//  DEPTH       61  number of entries, >=2, any integer
//  ADDR_WIDTH  6   pointer width; must satisfy 2**ADDR_WIDTH >= DEPTH
//  AFULL_TH    56  almost_full asserts when fill_cnt >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH   4   almost_empty asserts when fill_cnt <= AEMPTY_TH (0..DEPTH-1)
//  FWFT        0   0 = registered read, 1 cycle latency; 1 = head word visible on data_out while !empty
// PORTS
//  clk           in   1             rising-edge clock
//  rst_n         in   1             asynchronous active-low reset
//  flush         in   1             synchronous clear of contents and status
//  wr_en         in   1             write request
//  data_in       in   DATA_WIDTH    write data
//  rd_en         in   1             read (pop) request
//  data_out      out  DATA_WIDTH    read data
//  rd_valid      out  1             FWFT=0: one-cycle pulse, data_out updated this cycle; FWFT=1: equals !empty
//  empty         out  1             fill_cnt == 0
//  full          out  1             fill_cnt == DEPTH
//  almost_empty  out  1             fill_cnt <= AEMPTY_TH
//  almost_full   out  1             fill_cnt >= AFULL_TH
//  fill_cnt      out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: a write was rejected
//  underflow     out  1             sticky: a read was rejected
// BEHAVIOUR
//  - Reset (async, any time): pointers, fill_cnt, data_out, rd_valid, overflow, underflow = 0; empty=1,
//    almost_empty=1, full=0, almost_full=0. Memory array is not reset; its contents are not observable.
//  - rd_acc = rd_en & !empty. wr_acc = wr_en & (!full | rd_acc). Full + wr + rd: both accepted, fill_cnt unchanged.
//  - Empty + wr + rd: write accepted, read rejected (underflow=1), fill_cnt -> 1.
//  - fill_cnt_next = fill_cnt + wr_acc - rd_acc. All status outputs are combinational from registered fill_cnt.
//  - wr_acc: mem[wr_ptr] <= data_in; wr_ptr advances, wraps DEPTH-1 -> 0. rd_acc: rd_ptr same wrap rule.
//  - Rejected write (wr_en & !wr_acc) sets overflow. Rejected read (rd_en & empty) sets underflow.
//    Both flags hold until flush or reset.
//  - FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and rd_valid=1 next cycle; otherwise data_out holds, rd_valid=0.
//  - FWFT=1: data_out = empty ? 0 : mem[rd_ptr] (combinational); rd_en pops the head; next head visible the
//    cycle after pop. A word written into an empty FIFO appears on data_out the cycle after the write.
//  - Data written and read in the same cycle at a shared address: read returns the old (stored) word.
//  - flush: highest priority. Next cycle pointers=0, fill_cnt=0, overflow=underflow=0, data_out=0, rd_valid=0.
//    wr_en/rd_en in the flush cycle are ignored and do not set the sticky flags.
//  - Parameter violations (DEPTH<2, 2**ADDR_WIDTH<DEPTH, thresholds out of range): simulation $error at time 0.
// TESTING
//  1. Reset, write 0..60 (FWFT=0). Required: almost_full rises at fill_cnt=56; full=1, fill_cnt=61 after the 61st
//     write; 62nd write dropped, overflow=1.
//  2. Read 61 words. Required: data_out = 0..60, each one cycle after rd_en, with rd_valid pulse; empty=1 after last.
//     Extra rd_en: underflow=1, data_out holds 60.
//  3. Write 40, read 40, write 40, read 40. Required: pointers wrap 60->0; output order matches input; fill_cnt=0 at end.
//  4. At full, wr_en=rd_en=1 for 5 cycles. Required: fill_cnt stays 61, no overflow.
//     At empty, both=1. Required: fill_cnt=1, underflow=1.
//  5. Fill to 30, assert flush with wr_en=1. Required: next cycle fill_cnt=0, empty=1, flags 0; the write is discarded.
//  6. FWFT=1: write 25'h0A5. Required: data_out=0A5, rd_valid=1 next cycle with no rd_en.
//     Drop rst_n mid-burst. Required: all outputs reach reset values immediately.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable thresholds, fill count, sticky error flags,
// synchronous flush and a choice of registered or first-word-fall-through read.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 61,
  parameter int ADDR_WIDTH = 6,
  parameter int AFULL_TH   = 56,
  parameter int AEMPTY_TH  = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
      $error("param_sync_fifo: ADDR_WIDTH too small for DEPTH");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("param_sync_fifo: AFULL_TH out of range");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("param_sync_fifo: AEMPTY_TH out of range");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         fill_cnt_reg, fill_cnt_next;
  logic                  overflow_reg, underflow_reg;
  logic                  rd_acc, wr_acc;

  assign empty        = (fill_cnt_reg == '0);
  assign full         = (fill_cnt_reg == DEPTH_CNT);
  assign almost_empty = (fill_cnt_reg <= CW'(AEMPTY_TH));
  assign almost_full  = (fill_cnt_reg >= CW'(AFULL_TH));
  assign fill_cnt     = fill_cnt_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop at full frees the slot the simultaneous push lands in, so both proceed.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

  always_comb begin
    fill_cnt_next = fill_cnt_reg;
    case ({wr_acc, rd_acc})
      2'b10:   fill_cnt_next = fill_cnt_reg + CW'(1);
      2'b01:   fill_cnt_next = fill_cnt_reg - CW'(1);
      default: fill_cnt_next = fill_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      fill_cnt_reg <= fill_cnt_next;
      if (wr_acc) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (rd_acc) rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      if (wr_en && !wr_acc) overflow_reg <= 1'b1;
      if (rd_en && empty) underflow_reg <= 1'b1;
    end
  end

  // Storage is deliberately unreset; reads of a shared address see the stored (old) word.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr_reg];
      assign rd_valid = ~empty;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] data_out_reg;
      logic                  rd_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_reg <= '0;
          rd_valid_reg <= 1'b0;
        end else if (flush) begin
          data_out_reg <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) data_out_reg <= mem[rd_ptr_reg];
        end
      end

      assign data_out = data_out_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks both
// against a queue-based occupancy/ordering model every cycle.
module tb_param_sync_fifo;
  localparam int DW    = 25;
  localparam int DEPTH = 61;
  localparam int AF_TH = 56;
  localparam int AE_TH = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_en, rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, doutf;
  logic          rv0, rvf, emp0, empf, full0, fullf, ae0, aef, af0, aff, ovf0, ovff, udf0, udff;
  logic [6:0]    cnt0, cntf;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_dout;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(6), .AFULL_TH(AF_TH),
                    .AEMPTY_TH(AE_TH), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .rd_valid(rv0), .empty(emp0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .fill_cnt(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(6), .AFULL_TH(AF_TH),
                    .AEMPTY_TH(AE_TH), .FWFT(1'b1)) dutf (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(doutf), .rd_valid(rvf), .empty(empf), .full(fullf), .almost_empty(aef),
    .almost_full(aff), .fill_cnt(cntf), .overflow(ovff), .underflow(udff)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_rv   = 1'b0;
    m_dout = '0;
  endtask

  task automatic model_update(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    bit rd_ok, wr_ok;
    if (f) begin
      model_reset();
      return;
    end
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    if (r && !rd_ok) m_udf = 1'b1;
    if (w && !wr_ok) m_ovf = 1'b1;
    m_rv = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill_cnt",      cnt0, n);
    chk("fill_cnt_f",    cntf, n);
    chk("empty",         emp0, (n == 0));
    chk("empty_f",       empf, (n == 0));
    chk("full",          full0, (n == DEPTH));
    chk("full_f",        fullf, (n == DEPTH));
    chk("almost_empty",  ae0, (n <= AE_TH));
    chk("almost_empty_f", aef, (n <= AE_TH));
    chk("almost_full",   af0, (n >= AF_TH));
    chk("almost_full_f", aff, (n >= AF_TH));
    chk("overflow",      ovf0, m_ovf);
    chk("overflow_f",    ovff, m_ovf);
    chk("underflow",     udf0, m_udf);
    chk("underflow_f",   udff, m_udf);
    chk("data_out",      dout0, m_dout);
    chk("rd_valid",      rv0, m_rv);
    chk("data_out_f",    doutf, (n > 0) ? q[0] : '0);
    chk("rd_valid_f",    rvf, (n > 0));
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    model_update(w, d, r, f);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_all();
    $display("t=%0t wr=%0d din=%0h rd=%0d fl=%0d cnt=%0d dout=%0h rv=%0d doutf=%0h",
             $time, w, d, r, f, cnt0, dout0, rv0, doutf);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AF_TH - 2) chk("afull_below_th", af0, 1'b0);
      if (i == AF_TH - 1) chk("afull_at_th", af0, 1'b1);
    end
    chk("full_after_61", full0, 1'b1);
    chk("cnt_after_61", cnt0, 61);
    step(1'b1, DW'(61), 1'b0, 1'b0);
    chk("overflow_62nd", ovf0, 1'b1);

    // Drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_data", dout0, i);
      chk("drain_valid", rv0, 1'b1);
    end
    chk("empty_after_drain", emp0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("underflow_extra_rd", udf0, 1'b1);
    chk("data_hold_60", dout0, 60);

    // Pointer wrap: 40 in, 40 out, twice
    step(1'b0, '0, 1'b0, 1'b1);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 40; i++) step(1'b1, DW'(1000 + rep * 100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        step(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_order", dout0, 1000 + rep * 100 + i);
      end
    end
    chk("wrap_cnt_end", cnt0, 0);

    // Simultaneous read+write at full, then at empty
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      chk("full_rw_cnt", cnt0, 61);
      chk("full_rw_no_ovf", ovf0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, DW'(25'h1234), 1'b1, 1'b0);
    chk("empty_rw_cnt", cnt0, 1);
    chk("empty_rw_udf", udf0, 1'b1);

    // Flush with a concurrent write
    for (int i = 0; i < 29; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'(7), 1'b0, 1'b1);
    chk("flush_cnt", cnt0, 0);
    chk("flush_empty", emp0, 1'b1);
    chk("flush_udf", udf0, 1'b0);
    chk("flush_ovf", ovf0, 1'b0);

    // FWFT head visibility, then asynchronous reset mid-burst
    step(1'b1, DW'(25'h0A5), 1'b0, 1'b0);
    chk("fwft_head", doutf, 25'h0A5);
    chk("fwft_valid", rvf, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with phases biased toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = (i < 1000) ? 75 : (i < 2000) ? 35 : 55;
      rp = (i < 1000) ? 40 : (i < 2000) ? 75 : 50;
      step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
